// File: rtl/saradc_11b_dig_mackerel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : saradc_11b_dig_mackerel_pkg
// Brief    : Shared types and default widths for the mackerel request
//            sequencer (host-side initiator of the SAR ADC module).
// Revision : 1.0 - initial release
// ============================================================================
package saradc_11b_dig_mackerel_pkg;

    // Default channel-number and result widths of the mackerel interface
    localparam int unsigned c_def_chnr_w = 5;
    localparam int unsigned c_def_res_w  = 11;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_PWRUP = 3'd1,
        ST_IDLE  = 3'd2,
        ST_START = 3'd3,
        ST_CONV  = 3'd4
    } state_e;

endpackage : saradc_11b_dig_mackerel_pkg
`default_nettype wire

// File: rtl/ipdb_common_sync.sv
`default_nettype none
// ============================================================================
// Module   : ipdb_common_sync
// Brief    : Two-flop single-bit synchroniser (common library cell).
//            Only elaborated when SARADC_MACKEREL_REQ_SYNC_EN is defined, so
//            the default same-clock build carries no unused top-level cell.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef SARADC_MACKEREL_REQ_SYNC_EN
module ipdb_common_sync (
    input  logic clk_i,
    input  logic res_n_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    // Two-stage resynchronisation of an asynchronous level
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule : ipdb_common_sync
`endif
`default_nettype wire

// File: rtl/saradc_11b_dig_mackerel_req.sv
`default_nettype none
// ============================================================================
// Module   : saradc_11b_dig_mackerel_req
// Brief    : Host-side mackerel sequencer. Powers the SAR module up, issues
//            start_adc, tracks busy/eoc and returns each result through a
//            1-entry valid/ready output buffer. Timeouts and loss of
//            mod_ready raise a one-cycle err_timeout_o pulse.
//            Build option: SARADC_MACKEREL_REQ_SYNC_EN routes mod_ready_i,
//            busy_i and eoc_i through ipdb_common_sync (module running on an
//            unrelated clock); otherwise they are used directly.
// Revision : 1.0 - initial release
// ============================================================================
module saradc_11b_dig_mackerel_req
    import saradc_11b_dig_mackerel_pkg::*;
#(
    parameter int unsigned CHNR_W = c_def_chnr_w,
    parameter int unsigned RES_W  = c_def_res_w,
    parameter int unsigned TO_CYC = 1023
) (
    input  logic              clk_i,
    input  logic              res_n_i,
    input  logic              enable_i,
    input  logic              req_valid_i,
    input  logic [CHNR_W-1:0] req_chnr_i,
    output logic              req_ready_o,
    output logic              res_valid_o,
    output logic [RES_W-1:0]  res_data_o,
    output logic [CHNR_W-1:0] res_chnr_o,
    input  logic              res_ready_i,
    output logic              err_timeout_o,
    output logic              mod_enable_o,
    output logic              start_adc_o,
    output logic [CHNR_W-1:0] chnr_o,
    input  logic              mod_ready_i,
    input  logic              busy_i,
    input  logic              eoc_i,
    input  logic [RES_W-1:0]  result_i
);

    localparam int unsigned        c_cnt_w   = $clog2(TO_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_to_max  = c_cnt_w'(TO_CYC);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic w_mod_ready_s;
    logic w_busy_s;
    logic w_eoc_s;

`ifdef SARADC_MACKEREL_REQ_SYNC_EN
    ipdb_common_sync u_sync_mod_ready (
        .clk_i   (clk_i),
        .res_n_i (res_n_i),
        .d_i     (mod_ready_i),
        .q_o     (w_mod_ready_s)
    );

    ipdb_common_sync u_sync_busy (
        .clk_i   (clk_i),
        .res_n_i (res_n_i),
        .d_i     (busy_i),
        .q_o     (w_busy_s)
    );

    ipdb_common_sync u_sync_eoc (
        .clk_i   (clk_i),
        .res_n_i (res_n_i),
        .d_i     (eoc_i),
        .q_o     (w_eoc_s)
    );
`else
    assign w_mod_ready_s = mod_ready_i;
    assign w_busy_s      = busy_i;
    assign w_eoc_s       = eoc_i;
`endif

    state_e             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_mod_enable;
    logic               r_start_adc;
    logic               r_err;
    logic               r_res_valid;
    logic               r_eoc_d;
    logic               r_eoc_rise;
    logic [CHNR_W-1:0]  r_chnr;
    logic [CHNR_W-1:0]  r_res_chnr;
    logic [RES_W-1:0]   r_res_data;

    logic w_timeout;
    logic w_accept;
    logic w_pop;

    assign w_timeout = (r_cnt == c_to_max);
    assign w_pop     = r_res_valid & res_ready_i;

    // Ready only in IDLE when the FSM will really take the request: a
    // disable or a lost mod_ready in the same cycle would otherwise swallow
    // a handshake. A pop in the same cycle frees the buffer.
    assign req_ready_o = (r_state == ST_IDLE) & enable_i & w_mod_ready_s
                       & (~r_res_valid | res_ready_i);
    assign w_accept    = req_valid_i & req_ready_o;

    // Sequencer FSM with timeout counter, eoc edge detector and result buffer
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            r_state      <= ST_OFF;
            r_cnt        <= '0;
            r_mod_enable <= 1'b0;
            r_start_adc  <= 1'b0;
            r_err        <= 1'b0;
            r_res_valid  <= 1'b0;
            r_eoc_d      <= 1'b0;
            r_eoc_rise   <= 1'b0;
            r_chnr       <= '0;
            r_res_chnr   <= '0;
            r_res_data   <= '0;
        end else begin
            r_err      <= 1'b0;
            r_eoc_d    <= w_eoc_s;
            r_eoc_rise <= w_eoc_s & ~r_eoc_d;
            if (!w_timeout) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
            if (w_pop) begin
                r_res_valid <= 1'b0;
            end

            if (!enable_i) begin
                // Power down / abort: in-flight conversion dropped, buffer kept
                if (r_state != ST_OFF) begin
                    r_state <= ST_OFF;
                    r_cnt   <= '0;
                end
                r_mod_enable <= 1'b0;
                r_start_adc  <= 1'b0;
                r_eoc_d      <= 1'b0;
                r_eoc_rise   <= 1'b0;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        r_eoc_d      <= 1'b0;
                        r_eoc_rise   <= 1'b0;
                        r_mod_enable <= 1'b1;
                        r_state      <= ST_PWRUP;
                        r_cnt        <= '0;
                    end
                    ST_PWRUP: begin
                        if (w_mod_ready_s) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else if (w_timeout) begin
                            r_err        <= 1'b1;
                            r_mod_enable <= 1'b0;
                            r_state      <= ST_OFF;
                            r_cnt        <= '0;
                        end
                    end
                    ST_IDLE: begin
                        if (!w_mod_ready_s) begin
                            r_err   <= 1'b1;
                            r_state <= ST_PWRUP;
                            r_cnt   <= '0;
                        end else if (w_accept) begin
                            r_chnr      <= req_chnr_i;
                            r_start_adc <= 1'b1;
                            r_state     <= ST_START;
                            r_cnt       <= '0;
                        end
                    end
                    ST_START: begin
                        if (!w_mod_ready_s) begin
                            r_err       <= 1'b1;
                            r_start_adc <= 1'b0;
                            r_state     <= ST_PWRUP;
                            r_cnt       <= '0;
                        end else if (w_busy_s) begin
                            r_start_adc <= 1'b0;
                            r_state     <= ST_CONV;
                            r_cnt       <= '0;
                        end else if (w_timeout) begin
                            r_err       <= 1'b1;
                            r_start_adc <= 1'b0;
                            r_state     <= ST_IDLE;
                            r_cnt       <= '0;
                        end
                    end
                    ST_CONV: begin
                        // Only a registered rising edge counts, so an eoc
                        // still high from the last conversion is ignored
                        if (!w_mod_ready_s) begin
                            r_err   <= 1'b1;
                            r_state <= ST_PWRUP;
                            r_cnt   <= '0;
                        end else if (r_eoc_rise) begin
                            r_res_data  <= result_i;
                            r_res_chnr  <= r_chnr;
                            r_res_valid <= 1'b1;
                            r_state     <= ST_IDLE;
                            r_cnt       <= '0;
                        end else if (w_timeout) begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    default: begin
                        r_mod_enable <= 1'b0;
                        r_start_adc  <= 1'b0;
                        r_state      <= ST_OFF;
                        r_cnt        <= '0;
                    end
                endcase
            end
        end
    end

    assign res_valid_o   = r_res_valid;
    assign res_data_o    = r_res_data;
    assign res_chnr_o    = r_res_chnr;
    assign err_timeout_o = r_err;
    assign mod_enable_o  = r_mod_enable;
    assign start_adc_o   = r_start_adc;
    assign chnr_o        = r_chnr;

endmodule : saradc_11b_dig_mackerel_req
`default_nettype wire

// File: tb/tb_saradc_11b_dig_mackerel_req.sv
`default_nettype none
// ============================================================================
// Module   : tb_saradc_11b_dig_mackerel_req
// Brief    : Directed self-checking bench for the mackerel request sequencer.
//            The mackerel module side is modelled by hand-driven stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_saradc_11b_dig_mackerel_req;

    localparam int unsigned CHNR_W = 5;
    localparam int unsigned RES_W  = 11;
    localparam int unsigned TO_CYC = 40;
`ifdef SARADC_MACKEREL_REQ_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic              clk_i = 1'b0;
    logic              res_n_i;
    logic              enable_i;
    logic              req_valid_i;
    logic [CHNR_W-1:0] req_chnr_i;
    logic              req_ready_o;
    logic              res_valid_o;
    logic [RES_W-1:0]  res_data_o;
    logic [CHNR_W-1:0] res_chnr_o;
    logic              res_ready_i;
    logic              err_timeout_o;
    logic              mod_enable_o;
    logic              start_adc_o;
    logic [CHNR_W-1:0] chnr_o;
    logic              mod_ready_i;
    logic              busy_i;
    logic              eoc_i;
    logic [RES_W-1:0]  result_i;

    int n_pass  = 0;
    int n_total = 0;
    int n_start_rise = 0;

    saradc_11b_dig_mackerel_req #(
        .CHNR_W (CHNR_W),
        .RES_W  (RES_W),
        .TO_CYC (TO_CYC)
    ) u_dut (
        .clk_i         (clk_i),
        .res_n_i       (res_n_i),
        .enable_i      (enable_i),
        .req_valid_i   (req_valid_i),
        .req_chnr_i    (req_chnr_i),
        .req_ready_o   (req_ready_o),
        .res_valid_o   (res_valid_o),
        .res_data_o    (res_data_o),
        .res_chnr_o    (res_chnr_o),
        .res_ready_i   (res_ready_i),
        .err_timeout_o (err_timeout_o),
        .mod_enable_o  (mod_enable_o),
        .start_adc_o   (start_adc_o),
        .chnr_o        (chnr_o),
        .mod_ready_i   (mod_ready_i),
        .busy_i        (busy_i),
        .eoc_i         (eoc_i),
        .result_i      (result_i)
    );

    always #5 clk_i = ~clk_i;

    // Count start_adc rising edges seen by the module
    always @(posedge start_adc_o) n_start_rise++;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Bounded wait until the sequencer reports ready in IDLE
    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!req_ready_o && k < 100) begin
            tick(1);
            k++;
        end
        n_total++;
        if (req_ready_o !== 1'b1) $display("FAIL %s: req_ready_o=%b after %0d cycles, required 1", name, req_ready_o, k);
        else n_pass++;
    endtask

    task automatic test_reset;
        res_n_i = 1'b0; enable_i = 1'b0; req_valid_i = 1'b0; req_chnr_i = '0;
        res_ready_i = 1'b0; mod_ready_i = 1'b0; busy_i = 1'b0; eoc_i = 1'b0;
        result_i = '0;
        tick(3);
        n_total++;
        if ({mod_enable_o, start_adc_o, req_ready_o, res_valid_o, err_timeout_o} !== 5'b0)
            $display("FAIL reset_ctl: got %b required 00000",
                     {mod_enable_o, start_adc_o, req_ready_o, res_valid_o, err_timeout_o});
        else n_pass++;
        n_total++;
        if ({chnr_o, res_chnr_o, res_data_o} !== '0)
            $display("FAIL reset_data: chnr=%h res_chnr=%h res_data=%h required 0", chnr_o, res_chnr_o, res_data_o);
        else n_pass++;
        res_n_i = 1'b1;
        tick(2);
        n_total++;
        if (mod_enable_o !== 1'b0) $display("FAIL off_hold: mod_enable_o=%b required 0", mod_enable_o);
        else n_pass++;
    endtask

    task automatic test_powerup;
        enable_i = 1'b1;
        tick(1);
        n_total++;
        if (mod_enable_o !== 1'b1 || req_ready_o !== 1'b0)
            $display("FAIL pwrup_enter: mod_enable=%b req_ready=%b required 1/0", mod_enable_o, req_ready_o);
        else n_pass++;
        tick(4);
        mod_ready_i = 1'b1;
        tick(L);
        n_total++;
        if (req_ready_o !== 1'b0) $display("FAIL pwrup_wait: req_ready_o=%b required 0", req_ready_o);
        else n_pass++;
        tick(1);
        n_total++;
        if (req_ready_o !== 1'b1 || mod_enable_o !== 1'b1)
            $display("FAIL pwrup_idle: req_ready=%b mod_enable=%b required 1/1", req_ready_o, mod_enable_o);
        else n_pass++;
    endtask

    task automatic test_conversion;
        int rises0;
        rises0 = n_start_rise;
        req_valid_i = 1'b1; req_chnr_i = 5'd7;
        tick(1);
        req_valid_i = 1'b0;
        n_total++;
        if (start_adc_o !== 1'b1 || chnr_o !== 5'd7 || req_ready_o !== 1'b0)
            $display("FAIL conv_start: start=%b chnr=%0d req_ready=%b required 1/7/0", start_adc_o, chnr_o, req_ready_o);
        else n_pass++;
        tick(2);
        busy_i = 1'b1;
        tick(L);
        n_total++;
        if (start_adc_o !== 1'b1) $display("FAIL conv_start_hold: start_adc_o=%b required 1", start_adc_o);
        else n_pass++;
        tick(1);
        n_total++;
        if (start_adc_o !== 1'b0) $display("FAIL conv_busy: start_adc_o=%b required 0", start_adc_o);
        else n_pass++;
        tick(17);
        eoc_i = 1'b1; busy_i = 1'b0; result_i = 11'h5A3;
        tick(1 + L);
        n_total++;
        if (res_valid_o !== 1'b0) $display("FAIL conv_eoc_lat: res_valid_o=%b required 0", res_valid_o);
        else n_pass++;
        tick(1);
        n_total++;
        if (res_valid_o !== 1'b1 || res_data_o !== 11'h5A3 || res_chnr_o !== 5'd7)
            $display("FAIL conv_result: valid=%b data=%h chnr=%0d required 1/5a3/7", res_valid_o, res_data_o, res_chnr_o);
        else n_pass++;
        n_total++;
        if (n_start_rise - rises0 !== 1 || err_timeout_o !== 1'b0)
            $display("FAIL conv_start_count: rises=%0d err=%b required 1/0", n_start_rise - rises0, err_timeout_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        res_ready_i = 1'b0; req_valid_i = 1'b1; req_chnr_i = 5'd3;
        #1;
        n_total++;
        if (req_ready_o !== 1'b0) $display("FAIL b2b_full_block: req_ready_o=%b required 0", req_ready_o);
        else n_pass++;
        tick(1);
        n_total++;
        if (start_adc_o !== 1'b0 || res_valid_o !== 1'b1)
            $display("FAIL b2b_full_hold: start=%b valid=%b required 0/1", start_adc_o, res_valid_o);
        else n_pass++;
        res_ready_i = 1'b1;
        #1;
        n_total++;
        if (req_ready_o !== 1'b1) $display("FAIL b2b_pop_ready: req_ready_o=%b required 1", req_ready_o);
        else n_pass++;
        tick(1);
        res_ready_i = 1'b0; req_valid_i = 1'b0;
        n_total++;
        if (res_valid_o !== 1'b0 || start_adc_o !== 1'b1 || chnr_o !== 5'd3)
            $display("FAIL b2b_pop_accept: valid=%b start=%b chnr=%0d required 0/1/3", res_valid_o, start_adc_o, chnr_o);
        else n_pass++;
        // eoc_i is still high from the previous conversion
        busy_i = 1'b1;
        tick(1 + L);
        tick(4);
        n_total++;
        if (res_valid_o !== 1'b0 || start_adc_o !== 1'b0)
            $display("FAIL b2b_stale_eoc: valid=%b start=%b required 0/0", res_valid_o, start_adc_o);
        else n_pass++;
        eoc_i = 1'b0;
        tick(3);
        eoc_i = 1'b1; busy_i = 1'b0; result_i = 11'h0F1;
        tick(2 + L);
        n_total++;
        if (res_valid_o !== 1'b1 || res_data_o !== 11'h0F1 || res_chnr_o !== 5'd3)
            $display("FAIL b2b_result: valid=%b data=%h chnr=%0d required 1/0f1/3", res_valid_o, res_data_o, res_chnr_o);
        else n_pass++;
        res_ready_i = 1'b1;
        tick(1);
        res_ready_i = 1'b0; eoc_i = 1'b0;
        n_total++;
        if (res_valid_o !== 1'b0) $display("FAIL b2b_pop: res_valid_o=%b required 0", res_valid_o);
        else n_pass++;
    endtask

    task automatic test_timeout;
        int n;
        tick(L + 2);
        req_valid_i = 1'b1; req_chnr_i = 5'd9;
        tick(1);
        req_valid_i = 1'b0;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!err_timeout_o && n < 3 * TO_CYC);
        n_total++;
        if (n !== TO_CYC + 1) $display("FAIL to_delay: err after %0d cycles, required %0d", n, TO_CYC + 1);
        else n_pass++;
        n_total++;
        if (start_adc_o !== 1'b0 || req_ready_o !== 1'b1 || res_valid_o !== 1'b0)
            $display("FAIL to_idle: start=%b req_ready=%b valid=%b required 0/1/0", start_adc_o, req_ready_o, res_valid_o);
        else n_pass++;
        tick(1);
        n_total++;
        if (err_timeout_o !== 1'b0) $display("FAIL to_pulse: err_timeout_o=%b required 0", err_timeout_o);
        else n_pass++;
    endtask

    task automatic test_modready_drop;
        mod_ready_i = 1'b0;
        tick(L);
        n_total++;
        if (err_timeout_o !== 1'b0) $display("FAIL mrdy_early: err_timeout_o=%b required 0", err_timeout_o);
        else n_pass++;
        tick(1);
        n_total++;
        if (err_timeout_o !== 1'b1 || req_ready_o !== 1'b0 || mod_enable_o !== 1'b1)
            $display("FAIL mrdy_err: err=%b req_ready=%b mod_en=%b required 1/0/1", err_timeout_o, req_ready_o, mod_enable_o);
        else n_pass++;
        tick(1);
        n_total++;
        if (err_timeout_o !== 1'b0) $display("FAIL mrdy_pulse: err_timeout_o=%b required 0", err_timeout_o);
        else n_pass++;
        mod_ready_i = 1'b1;
        wait_idle("mrdy_recover");
    endtask

    task automatic test_enable_abort;
        req_valid_i = 1'b1; req_chnr_i = 5'd12;
        tick(1);
        req_valid_i = 1'b0; busy_i = 1'b1;
        tick(1 + L);
        enable_i = 1'b0;
        tick(1);
        n_total++;
        if (mod_enable_o !== 1'b0 || start_adc_o !== 1'b0 || req_ready_o !== 1'b0)
            $display("FAIL abort_off: mod_en=%b start=%b req_ready=%b required 0/0/0", mod_enable_o, start_adc_o, req_ready_o);
        else n_pass++;
        eoc_i = 1'b1; busy_i = 1'b0; result_i = 11'h2AA;
        tick(5);
        n_total++;
        if (res_valid_o !== 1'b0) $display("FAIL abort_discard: res_valid_o=%b required 0", res_valid_o);
        else n_pass++;
        eoc_i = 1'b0;
        enable_i = 1'b1;
        tick(L + 1);
        wait_idle("abort_reenable");
        req_valid_i = 1'b1; req_chnr_i = 5'd21;
        tick(1);
        req_valid_i = 1'b0; busy_i = 1'b1;
        tick(1 + L);
        tick(2);
        eoc_i = 1'b1; busy_i = 1'b0; result_i = 11'h7FF;
        tick(2 + L);
        n_total++;
        if (res_valid_o !== 1'b1 || res_data_o !== 11'h7FF)
            $display("FAIL keep_fill: valid=%b data=%h required 1/7ff", res_valid_o, res_data_o);
        else n_pass++;
        enable_i = 1'b0;
        tick(2);
        n_total++;
        if (mod_enable_o !== 1'b0 || res_valid_o !== 1'b1 || res_data_o !== 11'h7FF || res_chnr_o !== 5'd21)
            $display("FAIL keep_held: mod_en=%b valid=%b data=%h chnr=%0d required 0/1/7ff/21",
                     mod_enable_o, res_valid_o, res_data_o, res_chnr_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_conversion();
        test_back_to_back();
        test_timeout();
        test_modready_drop();
        test_enable_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_saradc_11b_dig_mackerel_req
`default_nettype wire
